// File: rtl/fifo_arb_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared definitions for the FIFO write arbiter slice:
//   - arb_state_e     : controller states (INIT -> CFG -> RUN)
//   - NREQ_DEF/DW_DEF : default requester count and data width
//   - RST_LIMIT_DEF   : threshold limit written to the FIFO after reset
//   - LIMIT_W         : width of the FIFO limit register
//   - idx_width()     : index width for an N-entry vector (at least 1 bit)
// Optional feature macro used by fifo_wr_arb: FIFO_ARB_THROTTLE_EN
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int RST_LIMIT_DEF = 8;
  localparam int LIMIT_W       = 8;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    CFG  = 2'd1,
    RUN  = 2'd2
  } arb_state_e;

  // A single requester still needs a 1-bit pointer/index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational rotate-priority picker. Starting at ptr_i and moving
// upwards (wrapping N-1 -> 0), the first set bit of elig_i wins.
// Ports:
//   elig_i  [N-1:0]  eligible requesters
//   ptr_i   [PW-1:0] highest-priority index this cycle (must be < N)
//   gnt_o   [N-1:0]  one-hot winner, zero when nothing is eligible
//   win_o   [PW-1:0] winner index (0 when valid_o is low)
//   valid_o          a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N  = NREQ_DEF,
  localparam int PW = idx_width(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] win_o,
  output logic          valid_o
);

  always_comb begin : pick
    int   idx;
    logic found;
    gnt_o   = '0;
    win_o   = '0;
    found   = 1'b0;
    idx     = 0;
    // Walk the N positions in priority order; ptr_i < N, so one
    // subtraction is enough to wrap.
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && elig_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        win_o      = PW'(idx);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// fifo_wr_arb
// Round-robin write arbiter in front of a FIFO. After reset it programs the
// FIFO limit register (INIT -> CFG -> RUN), then grants one requester per
// cycle into the FIFO. A cfg_load pulse in RUN latches a new limit and
// re-enters CFG to write it. Overflow pulses are counted (saturating).
//
// Optional feature: define FIFO_ARB_THROTTLE_EN to restrict eligibility to
// requester 0 while fifo_threshold is high. Without it fifo_threshold is
// ignored.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   req      [NREQ-1:0]     level write requests
//   req_data [NREQ*DW-1:0]  packed write data, requester i at [DW*i +: DW]
//   gnt      [NREQ-1:0]     one-hot grant (combinational, same cycle)
//   cfg_limit [7:0]         new limit value
//   cfg_load                one-cycle reprogram request (honoured in RUN only)
//   cfg_busy                high in INIT and CFG
//   fifo_full               blocks all grants
//   fifo_threshold          throttle input (feature macro only)
//   fifo_overflow           counted into ovf_count
//   fifo_wr_enb             FIFO data write strobe
//   fifo_wr_reg             FIFO limit-register write strobe
//   fifo_data [DW-1:0]      data or limit to FIFO, zero when no strobe
//   ovf_count [7:0]         saturating overflow count
// ---------------------------------------------------------------------------
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int RST_LIMIT = RST_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  input  logic [LIMIT_W-1:0] cfg_limit,
  input  logic               cfg_load,
  output logic               cfg_busy,
  input  logic               fifo_full,
  input  logic               fifo_threshold,
  input  logic               fifo_overflow,
  output logic               fifo_wr_enb,
  output logic               fifo_wr_reg,
  output logic [DW-1:0]      fifo_data,
  output logic [7:0]         ovf_count
);

  localparam int PW = idx_width(NREQ);

  arb_state_e         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [LIMIT_W-1:0] limit_q, limit_d;
  logic [7:0]         ovf_q, ovf_d;

  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    arb_gnt;
  logic [PW-1:0]      win;
  logic               win_valid;
  logic [DW-1:0]      req_slice [NREQ];

  // Unpack the flat data bus so the winner's word is a simple array read.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign req_slice[gi] = req_data[DW*gi +: DW];
  end

`ifdef FIFO_ARB_THROTTLE_EN
  // Near-threshold: only requester 0 may write. The pointer is still driven
  // by whoever actually wins, so fairness resumes from there.
  always_comb begin
    elig = req;
    if (fifo_threshold) begin
      elig = req & NREQ'(1);
    end
  end
`else
  logic unused_threshold;
  assign elig             = req;
  assign unused_threshold = fifo_threshold;
`endif

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .elig_i  (elig),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .win_o   (win),
    .valid_o (win_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= INIT;
      ptr_q   <= '0;
      limit_q <= LIMIT_W'(RST_LIMIT);
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      limit_q <= limit_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    limit_d     = limit_q;
    gnt         = '0;
    fifo_wr_enb = 1'b0;
    fifo_wr_reg = 1'b0;
    fifo_data   = '0;
    cfg_busy    = 1'b0;

    case (state_q)
      INIT: begin
        cfg_busy = 1'b1;
        state_d  = CFG;
      end
      CFG: begin
        cfg_busy    = 1'b1;
        fifo_wr_reg = 1'b1;
        fifo_data   = DW'(limit_q);
        state_d     = RUN;
      end
      RUN: begin
        // A reprogram request takes the cycle: no data write alongside it.
        if (cfg_load) begin
          limit_d = cfg_limit;
          state_d = CFG;
        end else if (!fifo_full && win_valid) begin
          gnt         = arb_gnt;
          fifo_wr_enb = 1'b1;
          fifo_data   = req_slice[win];
          ptr_d       = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    // Outputs are quiet for the whole reset window, including the cycle in
    // which rst_n first drops and the registers have not yet cleared.
    if (!rst_n) begin
      gnt         = '0;
      fifo_wr_enb = 1'b0;
      fifo_wr_reg = 1'b0;
      fifo_data   = '0;
      cfg_busy    = 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (fifo_overflow && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  assign ovf_count = rst_n ? ovf_q : 8'd0;

endmodule

// File: tb/tb_fifo_wr_arb.sv
module tb_fifo_wr_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  cfg_limit;
  logic        cfg_load;
  logic        cfg_busy;
  logic        fifo_full;
  logic        fifo_threshold;
  logic        fifo_overflow;
  logic        fifo_wr_enb;
  logic        fifo_wr_reg;
  logic [7:0]  fifo_data;
  logic [7:0]  ovf_count;

  fifo_wr_arb #(
    .NREQ      (4),
    .DW        (8),
    .RST_LIMIT (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req            (req),
    .req_data       (req_data),
    .gnt            (gnt),
    .cfg_limit      (cfg_limit),
    .cfg_load       (cfg_load),
    .cfg_busy       (cfg_busy),
    .fifo_full      (fifo_full),
    .fifo_threshold (fifo_threshold),
    .fifo_overflow  (fifo_overflow),
    .fifo_wr_enb    (fifo_wr_enb),
    .fifo_wr_reg    (fifo_wr_reg),
    .fifo_data      (fifo_data),
    .ovf_count      (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic       wr_enb;
    logic       wr_reg;
    logic [7:0] data;
    logic       busy;
    logic [7:0] ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: phase 0=INIT, 1=CFG, 2=RUN.
  int         m_phase = 0;
  int         m_ptr   = 0;
  int         m_limit = 8;
  int         m_ovf   = 0;
  logic [3:0] m_last_gnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs, predict the outputs, queue the prediction.
  task automatic apply(input logic r, input logic [3:0] rq, input logic [31:0] rd,
                       input logic ld, input logic [7:0] lim, input logic full,
                       input logic thr, input logic ov);
    exp_t       e;
    logic [3:0] el;
    logic       found;
    int         w;
    rst_n          = r;
    req            = rq;
    req_data       = rd;
    cfg_load       = ld;
    cfg_limit      = lim;
    fifo_full      = full;
    fifo_threshold = thr;
    fifo_overflow  = ov;
    e     = '0;
    found = 1'b0;
    if (!r) begin
      e.busy  = 1'b1;
      m_phase = 0;
      m_ptr   = 0;
      m_limit = 8;
      m_ovf   = 0;
    end else begin
      e.ovf = 8'(m_ovf);
      if (m_phase == 0) begin
        e.busy  = 1'b1;
        m_phase = 1;
      end else if (m_phase == 1) begin
        e.busy   = 1'b1;
        e.wr_reg = 1'b1;
        e.data   = 8'(m_limit);
        m_phase  = 2;
      end else if (ld) begin
        m_limit = int'(lim);
        m_phase = 1;
      end else if (!full) begin
        el = rq;
`ifdef FIFO_ARB_THROTTLE_EN
        if (thr) el = rq & 4'b0001;
`endif
        for (int k = 0; k < 4; k++) begin
          w = (m_ptr + k) % 4;
          if (!found && el[w]) begin
            found    = 1'b1;
            e.gnt[w] = 1'b1;
            e.wr_enb = 1'b1;
            e.data   = rd[w*8 +: 8];
            m_ptr    = (w + 1) % 4;
          end
        end
      end
      if (ov && m_ovf < 255) m_ovf++;
    end
    m_last_gnt = e.gnt;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    apply(1'b1, 4'b0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: compares every presented cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e, a;
    if (sb_q.size() > 0) begin
      e        = sb_q.pop_front();
      a.gnt    = gnt;
      a.wr_enb = fifo_wr_enb;
      a.wr_reg = fifo_wr_reg;
      a.data   = fifo_data;
      a.busy   = cfg_busy;
      a.ovf    = ovf_count;
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard cycle %0d: got gnt=%b enb=%b reg=%b data=%h busy=%b ovf=%0d, expected gnt=%b enb=%b reg=%b data=%h busy=%b ovf=%0d",
                 cyc, a.gnt, a.wr_enb, a.wr_reg, a.data, a.busy, a.ovf,
                 e.gnt, e.wr_enb, e.wr_reg, e.data, e.busy, e.ovf);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rr_seq [5];
    logic [3:0]  hreq;
    logic [31:0] hdat;

    rst_n = 1'b0; req = '0; req_data = '0; cfg_limit = '0; cfg_load = 1'b0;
    fifo_full = 1'b0; fifo_threshold = 1'b0; fifo_overflow = 1'b0;
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    hreq = '0;
    hdat = '0;
    step();

    // Reset state
    repeat (3) begin
      apply(1'b0, 4'hF, 32'hDEADBEEF, 1'b0, 8'h0, 1'b0, 1'b0, 1'b1); #2;
      chk("rst_busy", 32'(cfg_busy), 32'd1);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_strobes", 32'({fifo_wr_enb, fifo_wr_reg}), 32'd0);
      chk("rst_data", 32'(fifo_data), 32'd0);
      chk("rst_ovf", 32'(ovf_count), 32'd0);
      step();
    end

    // Reset release: INIT, CFG (limit 8), then RUN
    idle(); #2;
    chk("init_busy", 32'(cfg_busy), 32'd1);
    chk("init_reg", 32'(fifo_wr_reg), 32'd0);
    step();
    idle(); #2;
    chk("cfg_busy", 32'(cfg_busy), 32'd1);
    chk("cfg_reg", 32'(fifo_wr_reg), 32'd1);
    chk("cfg_data", 32'(fifo_data), 32'd8);
    step();
    idle(); #2;
    chk("run_busy", 32'(cfg_busy), 32'd0);
    step();

    // Round robin with all requesting
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 4'b1111, 32'h44332211, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0); #2;
      chk("rr_gnt", 32'(gnt), 32'(rr_seq[i]));
      chk("rr_data", 32'(fifo_data), 32'(8'h11 * ((i % 4) + 1)));
      step();
    end
    // Bring the pointer back to 0
    apply(1'b1, 4'b1000, 32'h55000000, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0); #2;
    chk("wrap_gnt", 32'(gnt), 32'b1000);
    step();

    // FIFO full blocks, pointer preserved
    repeat (2) begin
      apply(1'b1, 4'b0101, 32'h00660077, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0); #2;
      chk("full_gnt", 32'(gnt), 32'd0);
      chk("full_enb", 32'(fifo_wr_enb), 32'd0);
      step();
    end
    apply(1'b1, 4'b0101, 32'h00660077, 1'b0, 8'h0, 1'b0, 1'b0, 1'b0); #2;
    chk("unfull_gnt", 32'(gnt), 32'b0001);
    chk("unfull_data", 32'(fifo_data), 32'h77);
    step();

    // Limit reprogram
    apply(1'b1, 4'b0010, 32'h0000AB00, 1'b1, 8'd12, 1'b0, 1'b0, 1'b0); #2;
    chk("load_gnt", 32'(gnt), 32'd0);
    chk("load_enb", 32'(fifo_wr_enb), 32'd0);
    step();
    apply(1'b1, 4'b0010, 32'h0000AB00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0); #2;
    chk("reload_reg", 32'(fifo_wr_reg), 32'd1);
    chk("reload_data", 32'(fifo_data), 32'd12);
    chk("reload_gnt", 32'(gnt), 32'd0);
    step();
    apply(1'b1, 4'b0010, 32'h0000AB00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0); #2;
    chk("postload_gnt", 32'(gnt), 32'b0010);
    chk("postload_data", 32'(fifo_data), 32'hAB);
    step();

    // Reset in the middle of CFG restores the reset limit
    apply(1'b1, 4'b0, 32'h0, 1'b1, 8'd77, 1'b0, 1'b0, 1'b0);
    step();
    apply(1'b0, 4'b0, 32'h0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0); #2;
    chk("midcfg_rst_reg", 32'(fifo_wr_reg), 32'd0);
    step();
    idle();
    step();
    idle(); #2;
    chk("midcfg_relimit", 32'(fifo_data), 32'd8);
    step();

    // Overflow counter saturation
    for (int i = 0; i < 300; i++) begin
      apply(1'b1, 4'b0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b1);
      step();
    end
    idle(); #2;
    chk("ovf_sat", 32'(ovf_count), 32'd255);
    step();
    idle(); #2;
    chk("ovf_hold", 32'(ovf_count), 32'd255);
    step();

`ifdef FIFO_ARB_THROTTLE_EN
    apply(1'b1, 4'b1110, 32'h11223344, 1'b0, 8'h0, 1'b0, 1'b1, 1'b0); #2;
    chk("thr_block", 32'(gnt), 32'd0);
    chk("thr_enb", 32'(fifo_wr_enb), 32'd0);
    step();
    apply(1'b1, 4'b1111, 32'h11223344, 1'b0, 8'h0, 1'b0, 1'b1, 1'b0); #2;
    chk("thr_req0", 32'(gnt), 32'b0001);
    step();
`endif

    // Randomized traffic; requesters keep req and data until granted
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!hreq[i] || m_last_gnt[i]) begin
          hreq[i]         = ($urandom_range(0, 2) != 0);
          hdat[i*8 +: 8]  = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          hreq[i] = 1'b0;
        end
      end
      apply(($urandom_range(0, 249) != 0), hreq, hdat,
            ($urandom_range(0, 24) == 0), 8'($urandom),
            ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0));
      step();
    end

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
